// File: rtl/cap_axiw_arbiter.sv
// Two-master AXI write-channel arbiter: one whole burst (AW, W beats, B) per grant, W beat count enforced.
// Define CAP_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module cap_axiw_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                          ACLK,
  input  logic                          ARST,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_AWADDR,
  input  logic [7:0]                    S0_AWLEN,
  input  logic                          S0_AWVALID,
  output logic                          S0_AWREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] S0_WDATA,
  input  logic                          S0_WLAST,
  input  logic                          S0_WVALID,
  output logic                          S0_WREADY,
  output logic [1:0]                    S0_BRESP,
  output logic                          S0_BVALID,
  input  logic                          S0_BREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_AWADDR,
  input  logic [7:0]                    S1_AWLEN,
  input  logic                          S1_AWVALID,
  output logic                          S1_AWREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] S1_WDATA,
  input  logic                          S1_WLAST,
  input  logic                          S1_WVALID,
  output logic                          S1_WREADY,
  output logic [1:0]                    S1_BRESP,
  output logic                          S1_BVALID,
  input  logic                          S1_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [1:0]                    GRANT,
  output logic                          LEN_ERR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic [1:0] gnt;
  logic [7:0] beat_cnt;
  logic       len_err;
  logic       sel1;
  logic       cnt_zero;
  logic       g_wlast;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       pick_s1;

  assign sel1     = gnt[1];
  assign cnt_zero = (beat_cnt == 8'd0);
  assign g_wlast  = sel1 ? S1_WLAST : S0_WLAST;
  assign aw_hs    = (state == ADDR) && M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = (state == DATA) && M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs     = (state == RESP) && M_AXI_BVALID && M_AXI_BREADY;
  assign GRANT    = gnt;
  assign LEN_ERR  = len_err;

`ifdef CAP_ARB_FIXED_PRIO_EN
  assign pick_s1 = S1_AWVALID && !S0_AWVALID;
`else
  // last_s1 remembers the owner of the last completed burst; reset value lets S0 win the first tie
  logic last_s1;
  assign pick_s1 = (S0_AWVALID && S1_AWVALID) ? !last_s1 : S1_AWVALID;
`endif

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      beat_cnt <= 8'd0;
      len_err  <= 1'b0;
`ifndef CAP_ARB_FIXED_PRIO_EN
      last_s1  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (S0_AWVALID || S1_AWVALID) begin
            gnt   <= pick_s1 ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            beat_cnt <= M_AXI_AWLEN;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (g_wlast != cnt_zero) len_err <= 1'b1;
            // burst length comes from AWLEN, never from the requester's WLAST
            if (cnt_zero) state <= RESP;
            else          beat_cnt <= beat_cnt - 8'd1;
          end
        end
        RESP: begin
          if (b_hs) begin
`ifndef CAP_ARB_FIXED_PRIO_EN
            last_s1 <= gnt[1];
`endif
            gnt   <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_AXI_AWADDR  = sel1 ? S1_AWADDR : S0_AWADDR;
    M_AXI_AWLEN   = sel1 ? S1_AWLEN  : S0_AWLEN;
    M_AXI_WDATA   = sel1 ? S1_WDATA  : S0_WDATA;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    S0_AWREADY    = 1'b0;
    S1_AWREADY    = 1'b0;
    S0_WREADY     = 1'b0;
    S1_WREADY     = 1'b0;
    S0_BVALID     = 1'b0;
    S1_BVALID     = 1'b0;
    S0_BRESP      = gnt[0] ? M_AXI_BRESP : 2'b00;
    S1_BRESP      = gnt[1] ? M_AXI_BRESP : 2'b00;
    case (state)
      ADDR: begin
        M_AXI_AWVALID = sel1 ? S1_AWVALID : S0_AWVALID;
        S0_AWREADY    = gnt[0] & M_AXI_AWREADY;
        S1_AWREADY    = gnt[1] & M_AXI_AWREADY;
      end
      DATA: begin
        M_AXI_WVALID = sel1 ? S1_WVALID : S0_WVALID;
        M_AXI_WLAST  = cnt_zero;
        S0_WREADY    = gnt[0] & M_AXI_WREADY;
        S1_WREADY    = gnt[1] & M_AXI_WREADY;
      end
      RESP: begin
        M_AXI_BREADY = sel1 ? S1_BREADY : S0_BREADY;
        S0_BVALID    = gnt[0] & M_AXI_BVALID;
        S1_BVALID    = gnt[1] & M_AXI_BVALID;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cap_axiw_arbiter.sv
// Directed bench for cap_axiw_arbiter: drives both requesters and a scripted slave, checks routing and arbitration.
module tb_cap_axiw_arbiter;

  logic ACLK = 1'b0;
  logic ARST = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [1:0][31:0] awaddr = '0;
  logic [1:0][7:0]  awlen  = '0;
  logic [1:0]       awvalid = '0;
  logic [1:0][63:0] wdata  = '0;
  logic [1:0]       wlast  = '0;
  logic [1:0]       wvalid = '0;
  logic [1:0]       bready = '0;
  logic [1:0]       awready_s;
  logic [1:0]       wready_s;
  logic [1:0]       bvalid_s;
  logic [1:0][1:0]  bresp_s;

  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [63:0] m_wdata;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [1:0]  grant;
  logic        len_err;

  int n_tests = 0;
  int n_fail  = 0;

  cap_axiw_arbiter dut (
    .ACLK(ACLK), .ARST(ARST),
    .S0_AWADDR(awaddr[0]), .S0_AWLEN(awlen[0]), .S0_AWVALID(awvalid[0]), .S0_AWREADY(awready_s[0]),
    .S0_WDATA(wdata[0]), .S0_WLAST(wlast[0]), .S0_WVALID(wvalid[0]), .S0_WREADY(wready_s[0]),
    .S0_BRESP(bresp_s[0]), .S0_BVALID(bvalid_s[0]), .S0_BREADY(bready[0]),
    .S1_AWADDR(awaddr[1]), .S1_AWLEN(awlen[1]), .S1_AWVALID(awvalid[1]), .S1_AWREADY(awready_s[1]),
    .S1_WDATA(wdata[1]), .S1_WLAST(wlast[1]), .S1_WVALID(wvalid[1]), .S1_WREADY(wready_s[1]),
    .S1_BRESP(bresp_s[1]), .S1_BVALID(bvalid_s[1]), .S1_BREADY(bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
    .GRANT(grant), .LEN_ERR(len_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [63:0] pat(input int r, input logic [31:0] a, input int b);
    return {a, 8'(r), 16'hC0DE, 8'(b)};
  endfunction

  function automatic logic [9:0] quiet_outs();
    return {m_awvalid, m_wvalid, m_wlast, m_bready, awready_s, wready_s, bvalid_s};
  endfunction

  // One complete burst from requester r; the caller starts and ends on a negedge with the DUT idle.
  task automatic burst(input int r, input logic [31:0] addr, input logic [7:0] len, input int bad_beat,
                       input int aw_stall, input bit w_tog, input int b_delay, input bit keep_req,
                       input int abort_at);
    int o = 1 - r;
    int beats = 0;
    int k;
    bit done;
    bit other_bad = 1'b0;
    bit tog = 1'b1;
    bit le_chk = 1'b0;
    logic [1:0] g = 2'(1 << r);
    awaddr[r] = addr;
    awlen[r] = len;
    awvalid[r] = 1'b1;
    m_awready = 1'b0;
    #1;
    check("idle_no_awvalid", 64'(m_awvalid), 64'd0);
    step();
    check("grant_addr", 64'(grant), 64'(g));
    k = 0; done = 1'b0;
    while (!done && k < 100) begin
      m_awready = (k >= aw_stall);
      #1;
      if (k == 0) check("aw_fields", {23'd0, m_awvalid, m_awlen, m_awaddr}, {23'd0, 1'b1, len, addr});
      other_bad |= awready_s[o];
      if (m_awvalid && m_awready) begin
        check("aw_ready_route", 64'(awready_s[r]), 64'd1);
        done = 1'b1;
      end
      step(); k++;
    end
    if (!done) check("aw_timeout", 64'd0, 64'd1);
    m_awready = 1'b0;
    if (!keep_req) awvalid[r] = 1'b0;
    k = 0; done = 1'b0;
    while (!done && k < 200) begin
      wvalid[r] = 1'b1;
      wdata[r]  = pat(r, addr, beats);
      wlast[r]  = (bad_beat != 0) ? (beats == bad_beat - 1) : (beats == int'(len));
      m_wready  = w_tog ? tog : 1'b1;
      tog = ~tog;
      #1;
      other_bad |= wready_s[o];
      if (m_wvalid && m_wready) begin
        check("wdata", m_wdata, pat(r, addr, beats));
        check("wlast", 64'(m_wlast), 64'(beats == int'(len)));
        if (m_wlast) done = 1'b1;
        beats++;
      end
      step(); k++;
      if (bad_beat != 0 && beats == bad_beat && !le_chk) begin
        check("len_err_set", 64'(len_err), 64'd1);
        le_chk = 1'b1;
      end
      if (abort_at != 0 && beats == abort_at) begin
        ARST = 1'b1;
        wvalid[r] = 1'b0;
        awvalid[r] = 1'b0;
        m_wready = 1'b0;
        step();
        ARST = 1'b0;
        return;
      end
    end
    if (!done) check("w_timeout", 64'd0, 64'd1);
    check("beat_count", 64'(beats), 64'(int'(len) + 1));
    m_wready = 1'b1;
    wlast[r] = 1'b0;
    #1;
    check("no_w_in_resp", 64'(m_wvalid), 64'd0);
    wvalid[r] = 1'b0;
    m_wready = 1'b0;
    bready[r] = 1'b1;
    k = 0; done = 1'b0;
    while (!done && k < 100) begin
      m_bvalid = (k >= b_delay);
      m_bresp  = 2'(r + 1);
      #1;
      other_bad |= bvalid_s[o];
      if (k == 0) check("grant_resp", 64'(grant), 64'(g));
      if (m_bvalid) begin
        check("b_route", {60'd0, bvalid_s[r], bresp_s[r], m_bready}, {60'd0, 1'b1, 2'(r + 1), 1'b1});
        done = 1'b1;
      end
      step(); k++;
    end
    m_bvalid = 1'b0;
    bready[r] = 1'b0;
    if (!done) check("b_timeout", 64'd0, 64'd1);
    #1;
    check("grant_idle", 64'(grant), 64'd0);
    check("other_readys", 64'(other_bad), 64'd0);
  endtask

  task automatic do_reset();
    ARST = 1'b1;
    step();
    step();
    #1;
    check("rst_outs", 64'(quiet_outs()), 64'd0);
    check("rst_grant_lenerr", {61'd0, grant, len_err}, 64'd0);
    ARST = 1'b0;
  endtask

  initial begin
    int exp_r[4];
    @(negedge ACLK);
    do_reset();

    // S0 alone, 16 beats, no backpressure
    burst(0, 32'h2000_0000, 8'd15, 0, 0, 1'b0, 0, 1'b0, 0);

    // Both request every cycle: round-robin from reset (or fixed priority)
    do_reset();
`ifdef CAP_ARB_FIXED_PRIO_EN
    exp_r = '{0, 0, 0, 0};
`else
    exp_r = '{0, 1, 0, 1};
`endif
    awaddr[0] = 32'h1000_0000; awlen[0] = 8'd3; awvalid[0] = 1'b1;
    awaddr[1] = 32'h1100_0000; awlen[1] = 8'd3; awvalid[1] = 1'b1;
    for (int i = 0; i < 4; i++)
      burst(exp_r[i], exp_r[i] == 0 ? 32'h1000_0000 : 32'h1100_0000, 8'd3, 0, 0, 1'b0, 0, 1'b1, 0);
    awvalid = 2'b00;

    // S1 raises WLAST early on beat 2 of 4
    burst(1, 32'h4000_0040, 8'd3, 2, 0, 1'b0, 0, 1'b0, 0);
    check("len_err_after_burst", 64'(len_err), 64'd1);

    // Slave backpressure on all three phases; LEN_ERR must stay sticky
    burst(0, 32'h5000_0000, 8'd7, 0, 5, 1'b1, 10, 1'b0, 0);
    check("len_err_sticky", 64'(len_err), 64'd1);

    // Reset in the middle of a 16-beat burst after beat 7
    burst(0, 32'h6000_0000, 8'd15, 0, 0, 1'b0, 0, 1'b0, 7);
    #1;
    check("abort_outs", 64'(quiet_outs()), 64'd0);
    check("abort_grant_lenerr", {61'd0, grant, len_err}, 64'd0);

    // Fresh request after the abort
    burst(0, 32'h7000_0000, 8'd0, 0, 0, 1'b0, 2, 1'b0, 0);
    check("len_err_clean", 64'(len_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
